ro_freq_meter: RTL and testbench



---
 rtl/ro_meter_pkg.sv | 36 +++
 rtl/ro_edge_sync.sv | 38 +++
 rtl/ro_freq_meter.sv | 188 ++++++++++++++++++
 tb/tb_ro_freq_meter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meter_pkg.sv
// ============================================================================
//  Module      : ro_meter_pkg
//  Description : Shared types, default parameter values and helpers for the
//                ring-oscillator frequency meter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ro_meter_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } meter_state_t;

  // Default parameter values
  localparam int CNT_W_DEF         = 16;
  localparam int GATE_CYCLES_DEF   = 1024;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int AVG_LOG2_DEF      = 2;

  // Width of the shared SETTLE/GATE cycle timer. The timer counts from 0 to
  // (cycles - 1), so clog2 of the larger period is enough; never below 1 bit.
  function automatic int timer_width(input int settle_cycles, input int gate_cycles);
    int m;
    m = (settle_cycles > gate_cycles) ? settle_cycles : gate_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage : ro_meter_pkg

`default_nettype wire

// File: rtl/ro_edge_sync.sv
// ============================================================================
//  Module      : ro_edge_sync
//  Description : Multi-flop synchronizer for the asynchronous RO tap followed
//                by a rising-edge detector producing a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_edge_sync
  import ro_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Free-running synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : ro_edge_sync

`default_nettype wire

// File: rtl/ro_freq_meter.sv
// ============================================================================
//  Module      : ro_freq_meter
//  Description : Ring-oscillator reader. Enables the RO, lets it settle, then
//                counts synchronized rising edges over a fixed gate window and
//                returns the count on a valid/ready result port.
//                Optional macro RO_FREQ_METER_AVG_EN: averages 2^AVG_LOG2
//                back-to-back gate windows per start.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_CYCLES   = GATE_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
`ifdef RO_FREQ_METER_AVG_EN
  ,
  parameter int AVG_LOG2      = AVG_LOG2_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ro_en,
  input  logic             ro_q,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat
);

  localparam int               c_tw          = timer_width(SETTLE_CYCLES, GATE_CYCLES);
  localparam logic [c_tw-1:0]  c_settle_last = c_tw'(SETTLE_CYCLES - 1);
  localparam logic [c_tw-1:0]  c_gate_last   = c_tw'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  meter_state_t     r_state;
  logic [c_tw-1:0]  r_timer;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_sat_next;
  logic             w_gate_end;
  logic             w_last_win;
  logic [CNT_W-1:0] w_res_count;
  logic             w_res_sat;

  ro_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ro_q),
    .rise     (w_rise)
  );

  // Saturating window counter update; a rise at full scale sets the sticky flag
  always_comb begin
    w_cnt_next = r_cnt;
    w_sat_next = r_sat;
    if (w_rise) begin
      if (r_cnt == c_cnt_max) begin
        w_sat_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  assign w_gate_end = (r_state == GATE) && (r_timer == c_gate_last);

`ifdef RO_FREQ_METER_AVG_EN
  localparam int              c_aw       = CNT_W + AVG_LOG2;
  localparam int              c_ww       = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;
  localparam logic [c_ww-1:0] c_win_last = c_ww'((1 << AVG_LOG2) - 1);

  logic [c_aw-1:0] r_acc;
  logic [c_ww-1:0] r_win;
  logic            r_sat_any;
  logic [c_aw-1:0] w_acc_next;
  logic [c_aw-1:0] w_acc_shift;

  assign w_acc_next  = r_acc + c_aw'(w_cnt_next);
  assign w_acc_shift = w_acc_next >> AVG_LOG2;
  assign w_last_win  = (r_win == c_win_last);
  assign w_res_count = w_acc_shift[CNT_W-1:0];
  assign w_res_sat   = r_sat_any | w_sat_next;

  // Accumulate each finished window; cleared when a new measurement starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_win     <= '0;
      r_sat_any <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_acc     <= '0;
      r_win     <= '0;
      r_sat_any <= 1'b0;
    end else if (w_gate_end) begin
      r_acc     <= w_acc_next;
      r_win     <= r_win + 1'b1;
      r_sat_any <= w_res_sat;
    end
  end
`else
  assign w_last_win  = 1'b1;
  assign w_res_count = w_cnt_next;
  assign w_res_sat   = w_sat_next;
`endif

  // Measurement sequencer with registered RO enable, status and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      ro_en     <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SETTLE;
            r_timer <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            ro_en   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SETTLE: begin
          // Edges are ignored here; the synchronizer flushes while the RO starts
          if (r_timer == c_settle_last) begin
            r_state <= GATE;
            r_timer <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        GATE: begin
          if (r_timer == c_gate_last) begin
            // Window boundary: restart the per-window counter
            r_timer <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            if (w_last_win) begin
              r_state   <= DONE;
              ro_en     <= 1'b0;
              res_valid <= 1'b1;
              res_count <= w_res_count;
              res_sat   <= w_res_sat;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
            r_cnt   <= w_cnt_next;
            r_sat   <= w_sat_next;
          end
        end
        DONE: begin
          // start is deliberately not looked at here, even on the handshake cycle
          if (res_ready) begin
            r_state   <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : ro_freq_meter

`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
// ============================================================================
//  Module      : tb_ro_freq_meter
//  Description : Directed self-checking bench for ro_freq_meter. Two instances
//                share stimulus: a 16-bit counter and a 4-bit counter that
//                saturates. Honours RO_FREQ_METER_AVG_EN for expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ro_freq_meter;

  localparam int c_gate   = 1024;
  localparam int c_settle = 16;
`ifdef RO_FREQ_METER_AVG_EN
  localparam int c_windows = 4;
`else
  localparam int c_windows = 1;
`endif
  localparam int c_lat     = c_settle + c_windows * c_gate;
  localparam int c_exp_a   = 128;
  localparam int c_exp_b   = 15;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ro_q;
  logic        res_ready;

  logic        ro_en_a, busy_a, valid_a, sat_a;
  logic [15:0] count_a;
  logic        ro_en_b, busy_b, valid_b, sat_b;
  logic [3:0]  count_b;

  int errors = 0;
  int checks = 0;

  ro_freq_meter #(
    .CNT_W         (16),
    .GATE_CYCLES   (c_gate),
    .SETTLE_CYCLES (c_settle),
    .SYNC_STAGES   (2)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ro_en     (ro_en_a),
    .ro_q      (ro_q),
    .busy      (busy_a),
    .res_valid (valid_a),
    .res_ready (res_ready),
    .res_count (count_a),
    .res_sat   (sat_a)
  );

  ro_freq_meter #(
    .CNT_W         (4),
    .GATE_CYCLES   (c_gate),
    .SETTLE_CYCLES (c_settle),
    .SYNC_STAGES   (2)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ro_en     (ro_en_b),
    .ro_q      (ro_q),
    .busy      (busy_b),
    .res_valid (valid_b),
    .res_ready (res_ready),
    .res_count (count_b),
    .res_sat   (sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RO tap with an 8-clock period, phase-shifted away from clock edges
  initial begin
    ro_q = 1'b0;
    #3;
    forever #40 ro_q = ~ro_q;
  end

  // Pulse start for one cycle; returns #1 after the edge that sampled it
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until res_valid rises (bounded); flags any ro_en gap on the way
  task automatic wait_valid(output int n, output bit gap);
    n   = 0;
    gap = 1'b0;
    while ((n < c_lat + 50) && !valid_a) begin
      @(posedge clk);
      #1;
      n++;
      if (!valid_a && !ro_en_a) gap = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit act;
    rst_n     = 1'b0;
    start     = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ro_en_a, busy_a, valid_a, sat_a, count_a} !== 20'd0) begin
      errors++;
      $display("FAIL reset_a: got en=%b busy=%b valid=%b sat=%b count=%0d, required all 0",
               ro_en_a, busy_a, valid_a, sat_a, count_a);
    end
    checks++;
    if ({ro_en_b, busy_b, valid_b, sat_b, count_b} !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: got en=%b busy=%b valid=%b sat=%b count=%0d, required all 0",
               ro_en_b, busy_b, valid_b, sat_b, count_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    act   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (ro_en_a || busy_a || valid_a || (count_a != 16'd0) || ro_en_b || valid_b) act = 1'b1;
    end
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: got activity=%b, required 0", act);
    end
  endtask

  task automatic test_measure();
    int n;
    bit gap;
    do_start();
    checks++;
    if ({ro_en_a, busy_a} !== 2'b11) begin
      errors++;
      $display("FAIL start_accept: got en=%b busy=%b, required 1 1", ro_en_a, busy_a);
    end
    wait_valid(n, gap);
    checks++;
    if (n !== c_lat) begin
      errors++;
      $display("FAIL latency: got %0d edges, required %0d", n, c_lat);
    end
    checks++;
    if (count_a !== 16'(c_exp_a) || sat_a !== 1'b0) begin
      errors++;
      $display("FAIL count_a: got count=%0d sat=%b, required %0d 0", count_a, sat_a, c_exp_a);
    end
    checks++;
    if (count_b !== 4'(c_exp_b) || sat_b !== 1'b1) begin
      errors++;
      $display("FAIL count_sat_b: got count=%0d sat=%b, required %0d 1", count_b, sat_b, c_exp_b);
    end
    checks++;
    if (ro_en_a !== 1'b0 || busy_a !== 1'b1 || gap !== 1'b0) begin
      errors++;
      $display("FAIL en_at_done: got en=%b busy=%b gap=%b, required 0 1 0", ro_en_a, busy_a, gap);
    end
    // Handshake with a simultaneous start: start must be dropped
    @(negedge clk);
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    start     = 1'b0;
    checks++;
    if ({valid_a, busy_a, valid_b, busy_b} !== 4'b0000) begin
      errors++;
      $display("FAIL handshake: got valid=%b busy=%b, required 0 0", valid_a, busy_a);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ro_en_a, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL start_at_handshake: got en=%b busy=%b, required 0 0", ro_en_a, busy_a);
    end
  endtask

  task automatic test_hold();
    int n;
    bit gap;
    bit bad;
    do_start();
    wait_valid(n, gap);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) start = 1'b1;
      if (i == 11) start = 1'b0;
      @(posedge clk);
      #1;
      if (count_a !== 16'(c_exp_a) || !valid_a || !busy_a || ro_en_a || count_b !== 4'(c_exp_b)) bad = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL hold_stable: got unstable=%b, required 0 (count=%0d)", bad, count_a);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++;
    if ({busy_a, valid_a} !== 2'b00) begin
      errors++;
      $display("FAIL hold_release: got busy=%b valid=%b, required 0 0", busy_a, valid_a);
    end
    // res_ready while idle must not produce anything
    res_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++;
    if ({valid_a, busy_a, ro_en_a} !== 3'b000) begin
      errors++;
      $display("FAIL ready_idle: got valid=%b busy=%b en=%b, required 0 0 0", valid_a, busy_a, ro_en_a);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit gap;
    do_start();
    repeat (c_settle + 500) @(posedge clk);
    #1;
    checks++;
    if ({ro_en_a, busy_a, valid_a} !== 3'b110) begin
      errors++;
      $display("FAIL mid_gate: got en=%b busy=%b valid=%b, required 1 1 0", ro_en_a, busy_a, valid_a);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ro_en_a, busy_a, valid_a, sat_a, count_a, ro_en_b, sat_b, count_b} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset: got en=%b busy=%b count=%0d sat_b=%b count_b=%0d, required all 0",
               ro_en_a, busy_a, count_a, sat_b, count_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    wait_valid(n, gap);
    checks++;
    if (n !== c_lat || gap !== 1'b0) begin
      errors++;
      $display("FAIL relatency: got %0d edges gap=%b, required %0d 0", n, gap, c_lat);
    end
    checks++;
    if (count_a !== 16'(c_exp_a) || sat_a !== 1'b0 || count_b !== 4'(c_exp_b) || sat_b !== 1'b1) begin
      errors++;
      $display("FAIL recount: got a=%0d/%b b=%0d/%b, required %0d/0 %0d/1",
               count_a, sat_a, count_b, sat_b, c_exp_a, c_exp_b);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++;
    if ({busy_a, valid_a} !== 2'b00) begin
      errors++;
      $display("FAIL final_release: got busy=%b valid=%b, required 0 0", busy_a, valid_a);
    end
  endtask

  initial begin
    test_reset();
    test_measure();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ro_freq_meter

`default_nettype wire
